// File: rtl/sprite_layer_engine.sv
// Sprite layer engine: double-buffered sprite slots, replicated image RAMs and a shared
// palette. The renderer returns the winning sprite pixel three cycles after DrawX/DrawY.
module sprite_layer_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 20,
  parameter int NUM_IMAGES  = 8,
  parameter int IDX_BITS    = 3,
  parameter int COORD_W     = 10,
  localparam int SLOT_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int IMGSEL_W    = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int PIX_PER_IMG = SPR_W * SPR_H,
  localparam int IMG_DEPTH   = NUM_IMAGES * PIX_PER_IMG,
  localparam int IMG_AW      = $clog2(IMG_DEPTH)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                pix_valid_in,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  logic                reg_we,
  input  logic [SLOT_W-1:0]   reg_slot,
  input  logic [1:0]          reg_field,
  input  logic [15:0]         reg_wdata,
  input  logic                img_we,
  input  logic [IMG_AW-1:0]   img_addr,
  input  logic [IDX_BITS-1:0] img_wdata,
  input  logic                pal_we,
  input  logic [IDX_BITS-1:0] pal_addr,
  input  logic [23:0]         pal_wdata,
  output logic                pix_valid_out,
  output logic [7:0]          SpriteR,
  output logic [7:0]          SpriteG,
  output logic [7:0]          SpriteB,
  output logic                sprite_hit,
  output logic [SLOT_W-1:0]   hit_slot
);

  logic [COORD_W-1:0]  sh_x   [NUM_SPRITES];
  logic [COORD_W-1:0]  sh_y   [NUM_SPRITES];
  logic                sh_en  [NUM_SPRITES];
  logic                sh_fx  [NUM_SPRITES];
  logic                sh_fy  [NUM_SPRITES];
  logic [IMGSEL_W-1:0] sh_img [NUM_SPRITES];
  logic [COORD_W-1:0]  act_x  [NUM_SPRITES];
  logic [COORD_W-1:0]  act_y  [NUM_SPRITES];
  logic                act_en [NUM_SPRITES];
  logic                act_fx [NUM_SPRITES];
  logic                act_fy [NUM_SPRITES];
  logic [IMGSEL_W-1:0] act_img[NUM_SPRITES];

  logic slot_ok;
  logic ctrl_img_ok;
  logic img_ok;
  logic unused_bits;

  assign slot_ok     = 32'(reg_slot) < 32'(NUM_SPRITES);
  assign ctrl_img_ok = 32'(reg_wdata[IMGSEL_W-1:0]) < 32'(NUM_IMAGES);
  assign img_ok      = img_we && (32'(img_addr) < 32'(IMG_DEPTH));
  assign unused_bits = &{1'b0, reg_wdata};

  // Active copies load from the pre-write shadow, so a same-cycle write waits a frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        sh_x[s]    <= '0;
        sh_y[s]    <= '0;
        sh_en[s]   <= 1'b0;
        sh_fx[s]   <= 1'b0;
        sh_fy[s]   <= 1'b0;
        sh_img[s]  <= '0;
        act_x[s]   <= '0;
        act_y[s]   <= '0;
        act_en[s]  <= 1'b0;
        act_fx[s]  <= 1'b0;
        act_fy[s]  <= 1'b0;
        act_img[s] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int s = 0; s < NUM_SPRITES; s++) begin
          act_x[s]   <= sh_x[s];
          act_y[s]   <= sh_y[s];
          act_en[s]  <= sh_en[s];
          act_fx[s]  <= sh_fx[s];
          act_fy[s]  <= sh_fy[s];
          act_img[s] <= sh_img[s];
        end
      end
      if (reg_we && slot_ok) begin
        case (reg_field)
          2'd0: sh_x[reg_slot] <= reg_wdata[COORD_W-1:0];
          2'd1: sh_y[reg_slot] <= reg_wdata[COORD_W-1:0];
          2'd2: begin
            if (ctrl_img_ok) begin
              sh_img[reg_slot] <= reg_wdata[IMGSEL_W-1:0];
              sh_fy[reg_slot]  <= reg_wdata[IMGSEL_W];
              sh_fx[reg_slot]  <= reg_wdata[IMGSEL_W+1];
              sh_en[reg_slot]  <= reg_wdata[IMGSEL_W+2];
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [COORD_W-1:0]        dx_c   [NUM_SPRITES];
  logic [COORD_W-1:0]        dy_c   [NUM_SPRITES];
  logic [COORD_W-1:0]        lx_c   [NUM_SPRITES];
  logic [COORD_W-1:0]        ly_c   [NUM_SPRITES];
  logic [IMG_AW-1:0]         addr_c [NUM_SPRITES];
  logic [IMG_AW-1:0]         s1_addr[NUM_SPRITES];
  logic [NUM_SPRITES-1:0]    in_c;
  logic [NUM_SPRITES-1:0]    s1_in;
  logic [NUM_SPRITES-1:0]    s2_in;
  logic [NUM_SPRITES-1:0][IDX_BITS-1:0] s2_idx;
  logic                      v1;
  logic                      v2;

  // Offsets wrap modulo 2^COORD_W, so pixels left of or above the origin miss.
  always_comb begin
    for (int s = 0; s < NUM_SPRITES; s++) begin
      dx_c[s]   = DrawX - act_x[s];
      dy_c[s]   = DrawY - act_y[s];
      in_c[s]   = act_en[s] && (dx_c[s] < COORD_W'(SPR_W)) && (dy_c[s] < COORD_W'(SPR_H));
      lx_c[s]   = act_fx[s] ? (COORD_W'(SPR_W - 1) - dx_c[s]) : dx_c[s];
      ly_c[s]   = act_fy[s] ? (COORD_W'(SPR_H - 1) - dy_c[s]) : dy_c[s];
      addr_c[s] = '0;
      if (in_c[s]) begin
        addr_c[s] = IMG_AW'(act_img[s]) * IMG_AW'(PIX_PER_IMG)
                  + IMG_AW'(ly_c[s]) * IMG_AW'(SPR_W) + IMG_AW'(lx_c[s]);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      s1_in <= '0;
      s2_in <= '0;
      for (int s = 0; s < NUM_SPRITES; s++) s1_addr[s] <= '0;
    end else begin
      v1    <= pix_valid_in;
      v2    <= v1;
      s1_in <= in_c;
      s2_in <= s1_in;
      for (int s = 0; s < NUM_SPRITES; s++) s1_addr[s] <= addr_c[s];
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_img_ram
    logic [IDX_BITS-1:0] mem [IMG_DEPTH];
    logic [IDX_BITS-1:0] rd_q;
    always_ff @(posedge Clk) begin
      if (img_ok) mem[img_addr] <= img_wdata;
      rd_q <= mem[s1_addr[g]];
    end
    assign s2_idx[g] = rd_q;
  end

  logic [23:0] pal_mem [2**IDX_BITS];

  always_ff @(posedge Clk) begin
    if (pal_we) pal_mem[pal_addr] <= pal_wdata;
  end

  logic                win_found;
  logic [SLOT_W-1:0]   win_slot;
  logic [IDX_BITS-1:0] win_idx;
  logic [23:0]         win_rgb;

  // Scanning downward lets the lowest-numbered opaque slot overwrite the others.
  always_comb begin
    win_found = 1'b0;
    win_slot  = '0;
    win_idx   = '0;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (s2_in[s] && (s2_idx[s] != '0)) begin
        win_found = 1'b1;
        win_slot  = SLOT_W'(s);
        win_idx   = s2_idx[s];
      end
    end
    win_rgb = pal_mem[win_idx];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_valid_out <= 1'b0;
      sprite_hit    <= 1'b0;
      hit_slot      <= '0;
      SpriteR       <= '0;
      SpriteG       <= '0;
      SpriteB       <= '0;
    end else begin
      pix_valid_out <= v2;
      sprite_hit    <= win_found;
      hit_slot      <= win_found ? win_slot : '0;
      {SpriteR, SpriteG, SpriteB} <= win_found ? win_rgb : 24'h0;
    end
  end

endmodule
